// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, fetch FSM states and reset PC shared by the fetch unit.
package mips_pkg;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  typedef enum logic [1:0] {FETCH, WAIT, DISCARD} fetch_state_e;
  function automatic logic is_legal_op(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous instruction buffer with flush and simultaneous push/pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  always_comb begin
    do_pop = pop_i && count_q != '0;
    do_push = push_i && (count_q != CW'(DEPTH) || do_pop);
    data_o = mem_q[rd_q];
    valid_o = count_q != '0;
    count_o = count_q;
  end
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch with buffered output and branch redirect.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  op_code,
  output logic [31:0] instr_pc,
  output logic        instr_illegal,
  input  logic        branch_taken,
  input  logic [31:0] branch_target
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d;
  logic [CW-1:0] count;
  logic [63:0] head;
  logic fifo_valid, push, pop;
  // Outside FETCH a request is outstanding, so it (and its address) must be held.
  always_comb begin
    imem_req = !rst && (state_q != FETCH || count < CW'(FIFO_DEPTH));
    imem_addr = state_q == FETCH ? pc_q : addr_q;
    push = imem_req && imem_ack && state_q != DISCARD && !branch_taken;
    pop = instr_valid && instr_ready;
    addr_d = imem_addr;
    pc_d = branch_taken ? (branch_target & ~32'h3) : push ? imem_addr + 32'd4 : pc_q;
    state_d = (imem_req && !imem_ack) ? ((branch_taken || state_q == DISCARD) ? DISCARD : WAIT) : FETCH;
    instr_valid = !rst && fifo_valid;
    {instr, instr_pc} = head;
    op_code = instr[31:26];
    instr_illegal = instr_valid && !is_legal_op(op_code);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
    end
  end
  fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush_i(branch_taken),
    .push_i(push),
    .data_i({imem_rdata, imem_addr}),
    .pop_i(pop),
    .data_o(head),
    .valid_o(fifo_valid),
    .count_o(count)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenario tests for instr_fetch with hand-computed expectations.
module tb_instr_fetch;
  logic clk = 0, rst = 1;
  logic imem_req, imem_ack = 0, instr_valid, instr_ready = 0, instr_illegal, branch_taken = 0;
  logic [31:0] imem_addr, imem_rdata = 0, instr, instr_pc, branch_target = 0;
  logic [5:0] op_code;
  int checks = 0, failures = 0;
  instr_fetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .op_code(op_code), .instr_pc(instr_pc), .instr_illegal(instr_illegal),
    .branch_taken(branch_taken), .branch_target(branch_target)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1; imem_ack = 0; branch_taken = 0; instr_ready = 0; imem_rdata = 0;
    tick(); tick();
    rst = 0;
  endtask
  task automatic test_reset;
    rst = 1; imem_ack = 0; branch_taken = 0; instr_ready = 0;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %0h expected 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0h expected 0", instr_valid); end
    rst = 0; #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req: got %0h expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL first_addr: got %h expected 00000000", imem_addr); end
  endtask
  task automatic test_zero_wait;
    do_reset();
    imem_ack = 1; imem_rdata = 32'h8C01_0004; #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL zw_latency: got %0h expected 0", instr_valid); end
    tick(); imem_ack = 0; #1;
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL zw_valid: got %0h expected 1", instr_valid); end
    checks++; if (op_code !== 6'b100011) begin failures++; $display("FAIL zw_opcode: got %b expected 100011", op_code); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL zw_pc: got %h expected 00000000", instr_pc); end
    checks++; if (instr !== 32'h8C01_0004) begin failures++; $display("FAIL zw_instr: got %h expected 8c010004", instr); end
    checks++; if (instr_illegal !== 1'b0) begin failures++; $display("FAIL zw_illegal: got %0h expected 0", instr_illegal); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL zw_next: got req=%0h addr=%h expected req=1 addr=00000004", imem_req, imem_addr); end
  endtask
  task automatic test_backpressure;
    do_reset();
    imem_ack = 1; imem_rdata = 32'h0000_0020;
    tick(); imem_rdata = 32'h0000_0021; #1;
    checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL bp_addr1: got %h expected 00000004", imem_addr); end
    tick(); imem_ack = 0; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_stall%0d: got req=%0h expected 0", i, imem_req); end
      tick();
    end
    instr_ready = 1; #1;
    checks++; if (instr !== 32'h0000_0020 || instr_pc !== 32'h0) begin failures++; $display("FAIL bp_pop0: got %h@%h expected 00000020@00000000", instr, instr_pc); end
    tick();
    checks++; if (instr !== 32'h0000_0021 || instr_pc !== 32'h4) begin failures++; $display("FAIL bp_pop1: got %h@%h expected 00000021@00000004", instr, instr_pc); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL bp_resume: got req=%0h addr=%h expected req=1 addr=00000008", imem_req, imem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h8) begin failures++; $display("FAIL bp_drain: got valid=%0h addr=%h expected valid=0 addr=00000008", instr_valid, imem_addr); end
    imem_ack = 1; imem_rdata = 32'h0000_0022;
    tick(); imem_ack = 0; #1;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin failures++; $display("FAIL bp_third: got valid=%0h pc=%h expected valid=1 pc=00000008", instr_valid, instr_pc); end
  endtask
  task automatic test_branch_discard;
    do_reset();
    instr_ready = 1;
    tick(); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL bd_wait1: got req=%0h addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
    tick(); branch_taken = 1; branch_target = 32'h0000_0102; #1;
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL bd_hold: got %h expected 00000000", imem_addr); end
    tick(); branch_taken = 0; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL bd_ackaddr: got req=%0h addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
    tick(); imem_ack = 0; #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL bd_dropped: got valid=%0h expected 0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL bd_target: got req=%0h addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
    imem_ack = 1; imem_rdata = 32'h1000_0001;
    tick(); imem_ack = 0; #1;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin failures++; $display("FAIL bd_newpath: got valid=%0h pc=%h expected valid=1 pc=00000100", instr_valid, instr_pc); end
  endtask
  task automatic test_branch_ack_pop;
    do_reset();
    imem_ack = 1; imem_rdata = 32'h0000_0030;
    tick(); instr_ready = 1; imem_rdata = 32'h0000_0031; branch_taken = 1; branch_target = 32'h0000_0200; #1;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL bap_pop: got valid=%0h pc=%h expected valid=1 pc=00000000", instr_valid, instr_pc); end
    tick(); branch_taken = 0; imem_ack = 0; #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL bap_empty: got valid=%0h expected 0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL bap_target: got req=%0h addr=%h expected req=1 addr=00000200", imem_req, imem_addr); end
    imem_ack = 1; imem_rdata = 32'h0000_0040;
    tick(); imem_ack = 0; #1;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin failures++; $display("FAIL bap_next: got valid=%0h pc=%h expected valid=1 pc=00000200", instr_valid, instr_pc); end
  endtask
  task automatic test_discard_retarget;
    do_reset();
    tick(); branch_taken = 1; branch_target = 32'h0000_0300;
    tick(); branch_target = 32'h0000_0404;
    tick(); branch_taken = 0; imem_ack = 1; imem_rdata = 32'h0000_0050; #1;
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL dr_hold: got %h expected 00000000", imem_addr); end
    tick(); imem_ack = 0; #1;
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h404) begin failures++; $display("FAIL dr_newest: got valid=%0h addr=%h expected valid=0 addr=00000404", instr_valid, imem_addr); end
  endtask
  task automatic test_illegal_wrap;
    do_reset();
    instr_ready = 1; imem_ack = 1; imem_rdata = 32'h0000_0060; branch_taken = 1; branch_target = 32'hFFFF_FFFC;
    tick(); branch_taken = 0; imem_rdata = 32'h0800_0000; #1;
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL iw_addr: got valid=%0h addr=%h expected valid=0 addr=fffffffc", instr_valid, imem_addr); end
    tick(); imem_ack = 0; #1;
    checks++; if (instr_valid !== 1'b1 || instr_illegal !== 1'b1) begin failures++; $display("FAIL iw_illegal: got valid=%0h illegal=%0h expected 1/1", instr_valid, instr_illegal); end
    checks++; if (op_code !== 6'b000010 || instr_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL iw_head: got op=%b pc=%h expected 000010 fffffffc", op_code, instr_pc); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL iw_wrap: got req=%0h addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
  endtask
  task automatic test_back_to_back;
    do_reset();
    instr_ready = 1; imem_ack = 1; imem_rdata = 32'h0100_0000;
    for (int k = 1; k <= 6; k++) begin
      tick(); imem_rdata = 32'h0100_0000 + k; #1;
      checks++; if (instr_valid !== 1'b1 || instr !== 32'h0100_0000 + k - 1 || instr_pc !== 32'((k - 1) * 4)) begin failures++; $display("FAIL b2b_head%0d: got valid=%0h %h@%h expected 1 %h@%h", k, instr_valid, instr, instr_pc, 32'h0100_0000 + k - 1, 32'((k - 1) * 4)); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(k * 4)) begin failures++; $display("FAIL b2b_req%0d: got req=%0h addr=%h expected 1 %h", k, imem_req, imem_addr, 32'(k * 4)); end
    end
    imem_ack = 0;
  endtask
  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_branch_discard();
    test_branch_ack_pop();
    test_discard_retarget();
    test_illegal_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
